// File: rtl/multicycle_alu.sv
// Execution-stage ALU with valid/ready request and result handshakes.
// Shifts step one bit per cycle unless MULTICYCLE_ALU_BARREL_SHIFT_EN selects a one-cycle barrel shifter.
module multicycle_alu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluControl,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_SLL  = 4'b0011,
        OP_SLT  = 4'b0100,
        OP_SLTU = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_SRL  = 4'b1000,
        OP_SRA  = 4'b1010
    } op_e;

    state_e          state_q, state_d;
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;

    logic [SHW-1:0]  sh_amt;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;
    logic [XLEN-1:0] shift_step;

    assign sh_amt = b[SHW-1:0];

    // Request-side datapath; in the iterative build a shift here only covers the zero-amount case.
    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (aluControl)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
            OP_SLL:  alu_res = a << sh_amt;
            OP_SRL:  alu_res = a >> sh_amt;
            OP_SRA:  alu_res = $signed(a) >>> sh_amt;
`else
            OP_SLL, OP_SRL, OP_SRA: alu_res = a;
`endif
            default: alu_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (op_q)
            OP_SLL:  shift_step = {res_q[XLEN-2:0], 1'b0};
            OP_SRA:  shift_step = {res_q[XLEN-1], res_q[XLEN-1:1]};
            default: shift_step = {1'b0, res_q[XLEN-1:1]};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    illegal_d = alu_illegal;
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
                    if ((aluControl == OP_SLL || aluControl == OP_SRL || aluControl == OP_SRA)
                        && sh_amt != '0) begin
                        state_d = S_SHIFT;
                        op_d    = aluControl;
                        res_d   = a;
                        cnt_d   = sh_amt;
                        zero_d  = 1'b0;
                    end else
`endif
                    begin
                        state_d = S_DONE;
                        res_d   = alu_res;
                        zero_d  = (alu_res == '0);
                    end
                end
            end
            S_SHIFT: begin
                res_d = shift_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                    zero_d  = (shift_step == '0);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed and randomized checks of multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  aluControl;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        zero;
    logic        illegal;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_alu #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluControl (aluControl),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result and completion latency straight from the opcode table.
    function automatic void model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                                  output logic [63:0] r, output logic il, output int lat);
        int n;
        n   = int'(y[5:0]);
        il  = 1'b0;
        lat = 1;
        case (op)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = x ^ y;
            4'b0100: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b0101: r = (x < y) ? 64'd1 : 64'd0;
            4'b0011: r = x << n;
            4'b1000: r = x >> n;
            4'b1010: r = $signed(x) >>> n;
            default: begin r = 64'd0; il = 1'b1; end
        endcase
`ifndef MULTICYCLE_ALU_BARREL_SHIFT_EN
        if ((op == 4'b0011 || op == 4'b1000 || op == 4'b1010) && n > 0) lat = 1 + n;
`endif
    endfunction

    // Issue one request from IDLE and wait for its result; leaves the DUT holding it in DONE.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [63:0] av, input logic [63:0] bv);
        logic [63:0] er;
        logic        ei;
        int          lat;
        int          cyc;
        model(op, av, bv, er, ei, lat);
        chk({tag, ".in_ready"}, in_ready, 1);
        in_valid = 1'b1; aluControl = op; a = av; b = bv;
        @(posedge clk); #1;
        in_valid = 1'b0; aluControl = 4'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(lat));
        chk({tag, ".result"}, result, er);
        chk({tag, ".zero"}, zero, (er == 64'd0));
        chk({tag, ".illegal"}, illegal, ei);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".hs_in_ready"}, in_ready, 1);
        chk({tag, ".hs_out_valid"}, out_valid, 0);
    endtask

    logic [3:0]  ops [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                              4'b0011, 4'b1000, 4'b1010, 4'b0100, 4'b0101};
    logic [63:0] q_res [$];
    logic        q_il  [$];
    int          q_lat [$];
    int          q_acc [$];

    initial begin
        logic [63:0] ra, rb, er;
        logic [3:0]  rop;
        logic        ei, prev_ov;
        int          lat, cyc, accepted, done, acc_c;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluControl = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", result, 0);
        chk("rst.zero", zero, 0);
        chk("rst.illegal", illegal, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while a 40-step shift is in flight.
        in_valid = 1'b1; aluControl = 4'b0011; a = 64'd1; b = 64'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midop.busy_in_ready", in_ready, 0);
        chk("midop.busy_out_valid", out_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("midop.rst_out_valid", out_valid, 0);
        chk("midop.rst_in_ready", in_ready, 1);
        chk("midop.rst_result", result, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("add_after_rst", 4'b0010, 64'd2, 64'd3);
        chk("add_after_rst.const", result, 64'd5);
        handshake("add_after_rst");

        do_op("sub", 4'b0110, 64'd5, 64'd7);
        chk("sub.const", result, 64'hFFFF_FFFF_FFFF_FFFE);
        handshake("sub");
        do_op("slt", 4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("slt.const", result, 64'd1);
        handshake("slt");
        do_op("sltu", 4'b0101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("sltu.const", result, 64'd0);
        handshake("sltu");
        do_op("xor_eq", 4'b0111, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);
        chk("xor_eq.zero_const", zero, 1);
        handshake("xor_eq");

        do_op("sra63", 4'b1010, 64'h8000_0000_0000_0000, 64'd63);
        chk("sra63.const", result, 64'hFFFF_FFFF_FFFF_FFFF);
        handshake("sra63");
        do_op("srl63", 4'b1000, 64'h8000_0000_0000_0000, 64'd63);
        chk("srl63.const", result, 64'd1);
        handshake("srl63");
        do_op("sll0", 4'b0011, 64'd3, 64'd0);
        chk("sll0.const", result, 64'd3);
        handshake("sll0");
        do_op("sll_b45", 4'b0011, 64'd1, 64'h45);
        chk("sll_b45.const", result, 64'd32);
        handshake("sll_b45");

        // Backpressure: result must hold while out_ready stays low.
        do_op("bp", 4'b0010, 64'd1, 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("bp.hold_result", result, 64'd2);
            chk("bp.hold_out_valid", out_valid, 1);
            chk("bp.hold_in_ready", in_ready, 0);
        end
        handshake("bp");

        do_op("illegal", 4'b1111, 64'd7, 64'd9);
        chk("illegal.flag_const", illegal, 1);
        handshake("illegal");
        do_op("after_illegal", 4'b0001, 64'd4, 64'd1);
        chk("after_illegal.flag_const", illegal, 0);
        handshake("after_illegal");

        // Streaming: in_valid and out_ready held high, 10k random ops.
        out_ready = 1'b1;
        accepted = 0; done = 0; cyc = 0; prev_ov = 1'b0;
        while (done < 10000 && cyc < 90000) begin
            rop = ops[$urandom_range(0, 9)];
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) rb = ra;
            if ($urandom_range(0, 9) != 0) rb[5:0] = 6'($urandom_range(0, 7));
            in_valid = (accepted < 10000); aluControl = rop; a = ra; b = rb;
            if (in_valid && in_ready) begin
                model(rop, ra, rb, er, ei, lat);
                q_res.push_back(er); q_il.push_back(ei); q_lat.push_back(lat); q_acc.push_back(cyc);
                accepted++;
            end
            @(posedge clk); #1;
            cyc++;
            if (prev_ov) chk("stream.in_ready_after_hs", in_ready, 1);
            prev_ov = out_valid;
            if (out_valid) begin
                if (q_res.size() == 0) begin
                    chk("stream.unexpected_out_valid", 1, 0);
                end else begin
                    er = q_res.pop_front(); ei = q_il.pop_front();
                    lat = q_lat.pop_front(); acc_c = q_acc.pop_front();
                    chk("stream.result", result, er);
                    chk("stream.zero", zero, (er == 64'd0));
                    chk("stream.illegal", illegal, ei);
                    chk("stream.latency", 64'(cyc - acc_c), 64'(lat));
                end
                done++;
            end
        end
        in_valid = 1'b0;
        chk("stream.ops_completed", 64'(done), 64'd10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
